aer_tx_arbiter: RTL and testbench
=================================

AER_TX_ARBITER -- requirements
Module: aer_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of channel-FSM requesters (index 0=Ch1Up, 1=Ch1Down, 2=Ch2Up, 3=Ch2Down).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait for each sender acknowledge.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 Req  input  NREQ  level request per channel FSM (4-phase).
REQ-007 Fs_sen  input  1  sender has sensed frame start (acknowledge of Start).
REQ-008 Fe_d  input  1  sender frame-end done.
REQ-009 Gnt  output  NREQ  one-hot grant, at most one bit high.
REQ-010 Addr  output  2  address of granted requester: {channel-1, down}.
REQ-011 Start  output  1  one-cycle pulse requesting the sender to transmit Addr.
REQ-012 Busy  output  1  high in any state other than IDLE.
REQ-013 Err  output  1  sticky timeout flag.

Function
REQ-014 States SHALL be IDLE, GRANT, SEND, RELEASE, ABORT.
REQ-015 IDLE: if any Req bit is high, the winner w SHALL be selected round-robin, searching from index ptr+1 upward with wrap; the next state is GRANT.
REQ-016 Gnt[w] and Addr=w SHALL be registered and visible in the cycle after Req is sampled in IDLE (latency 1).
REQ-017 Start SHALL be high only in the first GRANT cycle.
REQ-018 GRANT: on Fs_sen=1, next state SEND; the timeout counter clears.
REQ-019 GRANT: if Req[w]=0 before Fs_sen, next state IDLE, Gnt cleared, ptr=w, no error.
REQ-020 SEND: on Fe_d=1, next state RELEASE and Gnt cleared; Req[w] dropping during SEND is ignored.
REQ-021 RELEASE: wait for Req[w]=0, then IDLE with ptr=w.
REQ-022 Timeout: an 8-bit counter (clog2(TIMEOUT+1)) SHALL count cycles in GRANT and in SEND; reaching TIMEOUT enters ABORT, clears Gnt, and sets Err.
REQ-023 ABORT: wait for Req[w]=0, then IDLE with ptr=w; Err stays set until reset.
REQ-024 Fs_sen and Fe_d both high in GRANT: take Fs_sen only (SEND); Fe_d is honoured on a later cycle.
REQ-025 Fs_sen or Fe_d outside its waiting state SHALL be ignored.
REQ-026 A minimum of one IDLE cycle SHALL separate consecutive grants.
REQ-027 Requests arriving while Busy SHALL be held by the requester and arbitrated at the next IDLE.
REQ-028 Gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-029 Reset SHALL give: state=IDLE, Gnt=0, Addr=0, Start=0, Busy=0, Err=0, counter=0, ptr=NREQ-1 (so index 0 wins first).
REQ-030 Reset asserted mid-transfer SHALL drop Gnt in the next cycle with no Start pulse; the sender is responsible for its own abort.

Structure
REQ-031 Package aer_pkg SHALL hold the state enum, NREQ default, requester index constants, and Addr encoding.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick (inputs Req and ptr; outputs a one-hot winner and a valid flag), purely combinational.

Verification
REQ-033 Req=0001 after reset -> Gnt=0001, Addr=00, Start pulse next cycle; Fs_sen at +3 and Fe_d at +6 -> Gnt=0 at +7; Req drop -> IDLE.
REQ-034 Req=1111 held for four transfers -> grant order 0,1,2,3, each separated by ≥1 IDLE cycle.
REQ-035 Grant of index 2 with Fs_sen never asserted -> ABORT after 255 GRANT cycles, Err=1, Gnt=0; Req drop -> IDLE, Err stays 1.
REQ-036 Req[1] withdrawn in GRANT before Fs_sen -> IDLE next cycle, Err=0, next winner search starts at 2.
REQ-037 Fs_sen=Fe_d=1 in the same GRANT cycle -> SEND only; Fe_d next cycle -> RELEASE.
REQ-038 Reset pulsed during SEND -> all outputs at reset values next cycle; Req=1000 then -> Gnt=1000.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared types and constants for the AER transmit arbiter.
package aer_pkg;

    // Default number of channel-FSM requesters.
    localparam int unsigned AerNreq = 4;

    // Requester indices.
    localparam int unsigned IdxCh1Up   = 0;
    localparam int unsigned IdxCh1Down = 1;
    localparam int unsigned IdxCh2Up   = 2;
    localparam int unsigned IdxCh2Down = 3;

    // Addr encoding is {channel-1, down}.
    localparam int unsigned AddrW = 2;
    localparam logic [AddrW-1:0] AddrCh1Up   = 2'b00;
    localparam logic [AddrW-1:0] AddrCh1Down = 2'b01;
    localparam logic [AddrW-1:0] AddrCh2Up   = 2'b10;
    localparam logic [AddrW-1:0] AddrCh2Down = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StSend,
        StRelease,
        StAbort
    } aer_state_e;

    // Map a requester index to its sender address.
    function automatic logic [AddrW-1:0] addr_of(input int unsigned idx);
        case (idx)
            IdxCh1Up:   return AddrCh1Up;
            IdxCh1Down: return AddrCh1Down;
            IdxCh2Up:   return AddrCh2Up;
            IdxCh2Down: return AddrCh2Down;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request above ptr, with wrap.
module rr_pick import aer_pkg::*; #(
    parameter int unsigned NREQ = AerNreq,
    parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    // Scan ptr+1 .. ptr+NREQ (mod NREQ); the last step revisits ptr itself.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!valid_o && req_i[IdxW'((32'(ptr_i) + k) % NREQ)]) begin
                gnt_o[IdxW'((32'(ptr_i) + k) % NREQ)] = 1'b1;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aer_tx_arbiter.sv
// Round-robin arbiter granting channel FSMs access to the AER sender.
module aer_tx_arbiter import aer_pkg::*; #(
    parameter int unsigned NREQ    = AerNreq,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  Req,
    input  logic             Fs_sen,
    input  logic             Fe_d,
    output logic [NREQ-1:0]  Gnt,
    output logic [AddrW-1:0] Addr,
    output logic             Start,
    output logic             Busy,
    output logic             Err
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    aer_state_e       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  win_oh;
    logic             win_valid;
    logic [IdxW-1:0]  win_idx;
    logic             timeout_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i   (Req),
        .ptr_i   (ptr_q),
        .gnt_o   (win_oh),
        .valid_o (win_valid)
    );

    // One-hot winner to index.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) win_idx = IdxW'(i);
        end
    end

    // The count is cleared on entry, so cycle n of a wait holds n-1.
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StGrant;
                    gnt_d   = win_oh;
                    idx_d   = win_idx;
                    addr_d  = addr_of(32'(win_idx));
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                // Fs_sen wins over a simultaneous Fe_d or request drop.
                if (Fs_sen) begin
                    state_d = StSend;
                    cnt_d   = '0;
                end else if (!Req[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    ptr_d   = idx_q;
                end else if (timeout_hit) begin
                    state_d = StAbort;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSend: begin
                if (Fe_d) begin
                    state_d = StRelease;
                    gnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = StAbort;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease, StAbort: begin
                if (!Req[idx_q]) begin
                    state_d = StIdle;
                    ptr_d   = idx_q;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= IdxW'(NREQ - 1);
            cnt_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign Gnt   = gnt_q;
    assign Addr  = addr_q;
    assign Start = start_q;
    assign Busy  = (state_q != StIdle);
    assign Err   = err_q;

endmodule

// File: tb/tb_aer_tx_arbiter.sv
// Directed self-checking bench for aer_tx_arbiter.
module tb_aer_tx_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       fs_sen;
    logic       fe_d;
    logic [3:0] gnt;
    logic [1:0] addr;
    logic       start;
    logic       busy;
    logic       err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    aer_tx_arbiter #(
        .NREQ    (4),
        .TIMEOUT (255)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Req    (req),
        .Fs_sen (fs_sen),
        .Fe_d   (fe_d),
        .Gnt    (gnt),
        .Addr   (addr),
        .Start  (start),
        .Busy   (busy),
        .Err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".gnt"},   32'(gnt),   32'h0);
        check({tag, ".addr"},  32'(addr),  32'h0);
        check({tag, ".start"}, 32'(start), 32'h0);
        check({tag, ".busy"},  32'(busy),  32'h0);
        check({tag, ".err"},   32'(err),   32'h0);
    endtask

    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        fs_sen = 1'b0;
        fe_d   = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_idle_reset("rst");

        // Single transfer from index 0.
        req = 4'b0001;
        step();
        check("t1.gnt", 32'(gnt), 32'h1);
        check("t1.addr", 32'(addr), 32'h0);
        check("t1.start", 32'(start), 32'h1);
        check("t1.busy", 32'(busy), 32'h1);
        step();
        check("t1.start_pulse", 32'(start), 32'h0);
        check("t1.gnt_held", 32'(gnt), 32'h1);
        fs_sen = 1'b1;
        step();
        fs_sen = 1'b0;
        step();
        step();
        fe_d = 1'b1;
        step();
        fe_d = 1'b0;
        check("t1.gnt_rel", 32'(gnt), 32'h0);
        check("t1.busy_rel", 32'(busy), 32'h1);
        step();
        check("t1.still_rel", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        check("t1.idle", 32'(busy), 32'h0);

        // Stray handshakes in IDLE are ignored.
        fs_sen = 1'b1;
        fe_d   = 1'b1;
        step();
        fs_sen = 1'b0;
        fe_d   = 1'b0;
        check("stray.busy", 32'(busy), 32'h0);
        check("stray.gnt", 32'(gnt), 32'h0);

        // Round-robin order 0,1,2,3 from reset with all requesting.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(1 << k));
            check($sformatf("rr%0d.addr", k), 32'(addr), 32'(k));
            check($sformatf("rr%0d.start", k), 32'(start), 32'h1);
            fs_sen = 1'b1;
            step();
            fs_sen = 1'b0;
            fe_d = 1'b1;
            step();
            fe_d = 1'b0;
            check($sformatf("rr%0d.gnt_rel", k), 32'(gnt), 32'h0);
            req[k] = 1'b0;
            step();
            check($sformatf("rr%0d.idle_gap", k), 32'(busy), 32'h0);
            check($sformatf("rr%0d.idle_gnt", k), 32'(gnt), 32'h0);
            req[k] = 1'b1;
        end

        // Withdrawal of index 1 in GRANT; next search starts at 2.
        req = 4'b0010;
        step();
        check("wd.gnt", 32'(gnt), 32'h2);
        step();
        req = 4'b0000;
        step();
        check("wd.busy", 32'(busy), 32'h0);
        check("wd.gnt0", 32'(gnt), 32'h0);
        check("wd.err", 32'(err), 32'h0);
        req = 4'b1111;
        step();
        check("wd.next", 32'(gnt), 32'h4);
        check("wd.next_addr", 32'(addr), 32'h2);

        // Index 2 with no Fs_sen: ABORT after 255 GRANT cycles.
        req = 4'b0100;
        for (int i = 0; i < 254; i++) step();
        check("to.still_grant", 32'(gnt), 32'h4);
        check("to.no_err_yet", 32'(err), 32'h0);
        step();
        check("to.gnt", 32'(gnt), 32'h0);
        check("to.err", 32'(err), 32'h1);
        check("to.busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        check("to.idle", 32'(busy), 32'h0);
        check("to.err_sticky", 32'(err), 32'h1);

        // Fs_sen and Fe_d together in GRANT: SEND only.
        req = 4'b1000;
        step();
        check("both.gnt", 32'(gnt), 32'h8);
        fs_sen = 1'b1;
        fe_d   = 1'b1;
        step();
        fs_sen = 1'b0;
        check("both.send_gnt", 32'(gnt), 32'h8);
        check("both.send_busy", 32'(busy), 32'h1);
        step();
        fe_d = 1'b0;
        check("both.rel_gnt", 32'(gnt), 32'h0);
        req = 4'b0000;
        step();
        check("both.idle", 32'(busy), 32'h0);

        // Reset during SEND.
        req = 4'b0001;
        step();
        check("rs.gnt", 32'(gnt), 32'h1);
        fs_sen = 1'b1;
        step();
        fs_sen = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_reset("rs.after");
        req = 4'b1000;
        step();
        check("rs.regrant", 32'(gnt), 32'h8);
        check("rs.addr", 32'(addr), 32'h3);
        check("rs.start", 32'(start), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
